// File: rtl/urv_dmem_wb_bridge_if.sv
// Wishbone B4 pipelined bus bundle between the data-memory bridge (master)
// and the memory/peripheral fabric (slave).
interface urv_dmem_wb_bridge_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
endinterface

// File: rtl/urv_dmem_wb_bridge.sv
// Turns single-cycle load/store pulses from the core's data port into one
// Wishbone B4 pipelined single access each, with a WAIT-state timeout.
module urv_dmem_wb_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_err_o,
  output logic        dm_overlap_err_o,
  urv_dmem_wb_bridge_if.master wb
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [9:0]  count, count_next;
  logic        we_q, we_next;
  logic [3:0]  sel_q, sel_next;
  logic [31:0] adr_q, adr_next;
  logic [31:0] dat_q, dat_next;
  logic [31:0] data_l_q, data_l_next;
  logic        load_done_q, load_done_next;
  logic        store_done_q, store_done_next;
  logic        bus_err_q, bus_err_next;
  logic        overlap_q, overlap_next;
  logic        respond;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^dm_addr_i[1:0];

  // Bus strobes and ready decode straight from the state register.
  assign dm_ready_o       = (state == IDLE);
  assign wb.wb_cyc_o      = (state != IDLE);
  assign wb.wb_stb_o      = (state == ISSUE);
  assign wb.wb_we_o       = we_q;
  assign wb.wb_sel_o      = sel_q;
  assign wb.wb_adr_o      = adr_q;
  assign wb.wb_dat_o      = dat_q;
  assign dm_data_l_o      = data_l_q;
  assign dm_load_done_o   = load_done_q;
  assign dm_store_done_o  = store_done_q;
  assign dm_bus_err_o     = bus_err_q;
  assign dm_overlap_err_o = overlap_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      count        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      data_l_q     <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      bus_err_q    <= 1'b0;
      overlap_q    <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      we_q         <= we_next;
      sel_q        <= sel_next;
      adr_q        <= adr_next;
      dat_q        <= dat_next;
      data_l_q     <= data_l_next;
      load_done_q  <= load_done_next;
      store_done_q <= store_done_next;
      bus_err_q    <= bus_err_next;
      overlap_q    <= overlap_next;
    end
  end

  always_comb begin
    state_next      = state;
    count_next      = count;
    we_next         = we_q;
    sel_next        = sel_q;
    adr_next        = adr_q;
    dat_next        = dat_q;
    data_l_next     = data_l_q;
    load_done_next  = 1'b0;
    store_done_next = 1'b0;
    bus_err_next    = 1'b0;
    overlap_next    = overlap_q | ((state != IDLE) & (dm_load_i | dm_store_i));
    respond         = 1'b0;

    case (state)
      IDLE: begin
        if (dm_load_i | dm_store_i) begin
          adr_next   = {dm_addr_i[31:2], 2'b00};
          sel_next   = dm_data_select_i;
          dat_next   = dm_data_s_i;
          we_next    = dm_store_i;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!wb.wb_stall_i) begin
          state_next = WAIT;
          respond    = wb.wb_ack_i | wb.wb_err_i;
        end
      end
      WAIT: begin
        count_next = (count == 10'h3ff) ? count : count + 10'd1;
        respond    = wb.wb_ack_i | wb.wb_err_i | (count == TIMEOUT_LAST);
      end
      default: state_next = IDLE;
    endcase

    // Without an ack, a response here is either err or the timeout; err beats ack.
    if (respond) begin
      bus_err_next    = wb.wb_err_i | ~wb.wb_ack_i;
      load_done_next  = ~we_q;
      store_done_next = we_q;
      if (bus_err_next)
        data_l_next = '0;
      else if (!we_q)
        data_l_next = wb.wb_dat_i;
      count_next = '0;
      state_next = IDLE;
    end
  end

endmodule

// File: tb/tb_urv_dmem_wb_bridge.sv
// Directed, table-driven bench for urv_dmem_wb_bridge with an in-bench
// Wishbone slave that stalls and responds on scripted cycles.
module tb_urv_dmem_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_bus_err_o;
  logic        dm_overlap_err_o;

  int testsRun = 0;
  int testsFailed = 0;

  urv_dmem_wb_bridge_if wb();

  urv_dmem_wb_bridge #(.TIMEOUT(8)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .dm_addr_i        (dm_addr_i),
    .dm_data_s_i      (dm_data_s_i),
    .dm_data_select_i (dm_data_select_i),
    .dm_load_i        (dm_load_i),
    .dm_store_i       (dm_store_i),
    .dm_ready_o       (dm_ready_o),
    .dm_data_l_o      (dm_data_l_o),
    .dm_load_done_o   (dm_load_done_o),
    .dm_store_done_o  (dm_store_done_o),
    .dm_bus_err_o     (dm_bus_err_o),
    .dm_overlap_err_o (dm_overlap_err_o),
    .wb               (wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        doLoad;
    logic        doStore;
    logic [31:0] addr;
    logic [31:0] dataS;
    logic [3:0]  sel;
    int          stall;
    int          delay;
    logic        respAck;
    logic        respErr;
    logic [31:0] rdata;
    logic [31:0] expAdr;
    logic        expWe;
    int          expDone;
    logic [2:0]  expPulses;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [9];
  vec_t finalVec;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] pulses();
    return 32'({dm_load_done_o, dm_store_done_o, dm_bus_err_o});
  endfunction

  // Request is driven in the current cycle; k counts cycles after it.
  task automatic applyStimulus(input vec_t v, input string tag);
    int acc;
    int rsp;
    acc = 1 + v.stall;
    rsp = acc + v.delay;
    dm_load_i        = v.doLoad;
    dm_store_i       = v.doStore;
    dm_addr_i        = v.addr;
    dm_data_s_i      = v.dataS;
    dm_data_select_i = v.sel;
    for (int k = 1; k <= v.expDone; k++) begin
      @(negedge clk);
      dm_load_i     = 1'b0;
      dm_store_i    = 1'b0;
      wb.wb_stall_i = (k < acc);
      wb.wb_ack_i   = v.respAck && (k == rsp);
      wb.wb_err_i   = v.respErr && (k == rsp);
      wb.wb_dat_i   = (k == rsp) ? v.rdata : 32'h0BAD0BAD;
      if (k < v.expDone) begin
        checkOutput({tag, " busy cyc/ready/stb"}, 32'({wb.wb_cyc_o, dm_ready_o, wb.wb_stb_o}),
                    32'({1'b1, 1'b0, (k <= acc)}));
        checkOutput({tag, " busy pulses"}, pulses(), 32'd0);
        if (k <= acc) begin
          checkOutput({tag, " adr"}, wb.wb_adr_o, v.expAdr);
          checkOutput({tag, " sel"}, 32'(wb.wb_sel_o), 32'(v.sel));
          checkOutput({tag, " dat"}, wb.wb_dat_o, v.dataS);
          checkOutput({tag, " we"}, 32'(wb.wb_we_o), 32'(v.expWe));
        end
      end else begin
        wb.wb_stall_i = 1'b0;
        wb.wb_ack_i   = 1'b0;
        wb.wb_err_i   = 1'b0;
        checkOutput({tag, " done cyc/stb/ready"}, 32'({wb.wb_cyc_o, wb.wb_stb_o, dm_ready_o}), 32'b001);
        checkOutput({tag, " done pulses"}, pulses(), 32'(v.expPulses));
        checkOutput({tag, " load data"}, dm_data_l_o, v.expData);
        checkOutput({tag, " overlap"}, 32'(dm_overlap_err_o), 32'd0);
      end
    end
  endtask

  initial begin
    // load, store, addr, data_s, sel, stall, delay, ack, err, rdata | adr, we, done, {ld,st,err}, data_l
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 0, 1, 1'b1, 1'b0, 32'hDEAD_BEEF,
                32'h0000_1004, 1'b0, 3, 3'b100, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2003, 32'h5A5A_5A5A, 4'b1000, 3, 1, 1'b1, 1'b0, 32'h0,
                32'h0000_2000, 1'b1, 6, 3'b010, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 32'h0,
                32'h0000_3000, 1'b0, 10, 3'b101, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_4008, 32'h1122_3344, 4'hF, 0, 1, 1'b1, 1'b1, 32'h0,
                32'h0000_4008, 1'b1, 3, 3'b011, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_5006, 32'h0, 4'b1100, 1, 0, 1'b1, 1'b0, 32'h1234_5678,
                32'h0000_5004, 1'b0, 3, 3'b100, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 0, 2, 1'b0, 1'b1, 32'hCAFE_F00D,
                32'h0000_6000, 1'b0, 4, 3'b101, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 2, 7, 1'b1, 1'b0, 32'hA5A5_0F0F,
                32'h0000_7000, 1'b0, 11, 3'b100, 32'hA5A5_0F0F};
    vecs[7] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'h7777_7777, 4'b0011, 0, 1, 1'b1, 1'b0, 32'h0,
                32'hFFFF_FFFC, 1'b1, 3, 3'b010, 32'hA5A5_0F0F};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_8000, 32'h9999_9999, 4'hF, 0, 1, 1'b1, 1'b0, 32'hBADB_AD00,
                32'h0000_8000, 1'b1, 3, 3'b010, 32'hA5A5_0F0F};
    finalVec = '{1'b1, 1'b0, 32'h0000_B010, 32'h0, 4'hF, 0, 1, 1'b1, 1'b0, 32'h600D_F00D,
                 32'h0000_B010, 1'b0, 3, 3'b100, 32'h600D_F00D};

    rst_i            = 1'b1;
    dm_addr_i        = '0;
    dm_data_s_i      = '0;
    dm_data_select_i = '0;
    dm_load_i        = 1'b0;
    dm_store_i       = 1'b0;
    wb.wb_dat_i      = '0;
    wb.wb_ack_i      = 1'b0;
    wb.wb_err_i      = 1'b0;
    wb.wb_stall_i    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", 32'(dm_ready_o), 32'd1);
    checkOutput("reset data", dm_data_l_o, 32'd0);
    checkOutput("reset pulses/overlap", 32'({pulses(), dm_overlap_err_o}), 32'd0);
    checkOutput("reset cyc/stb/we/sel", 32'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o}), 32'd0);
    checkOutput("reset adr", wb.wb_adr_o, 32'd0);
    checkOutput("reset dat", wb.wb_dat_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Each vector starts in the previous one's done cycle, so these run back-to-back.
    for (int i = 0; i < 9; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Second load issued while the first is in WAIT.
    dm_load_i = 1'b1; dm_addr_i = 32'h0000_9000; dm_data_select_i = 4'hF;
    @(negedge clk);
    dm_load_i = 1'b0;
    checkOutput("ovl issue stb", 32'(wb.wb_stb_o), 32'd1);
    @(negedge clk);
    dm_load_i = 1'b1; dm_addr_i = 32'h0000_9100;
    checkOutput("ovl wait cyc/stb", 32'({wb.wb_cyc_o, wb.wb_stb_o}), 32'b10);
    @(negedge clk);
    dm_load_i = 1'b0;
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h0F1E_2D3C;
    checkOutput("ovl flag set", 32'(dm_overlap_err_o), 32'd1);
    checkOutput("ovl no new beat", 32'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_adr_o[15:0]}), 32'h2_9000);
    @(negedge clk);
    wb.wb_ack_i = 1'b0;
    checkOutput("ovl done pulses", pulses(), 32'b100);
    checkOutput("ovl data", dm_data_l_o, 32'h0F1E_2D3C);
    checkOutput("ovl done ready/cyc", 32'({dm_ready_o, wb.wb_cyc_o}), 32'b10);
    @(negedge clk);
    checkOutput("ovl after cyc/stb", 32'({wb.wb_cyc_o, wb.wb_stb_o}), 32'd0);
    checkOutput("ovl sticky", 32'(dm_overlap_err_o), 32'd1);
    checkOutput("ovl after pulses", pulses(), 32'd0);

    // Reset while a beat is held stalled in ISSUE.
    dm_load_i = 1'b1; dm_addr_i = 32'h0000_A000;
    @(negedge clk);
    dm_load_i = 1'b0; wb.wb_stall_i = 1'b1;
    checkOutput("rst issue stb", 32'(wb.wb_stb_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    checkOutput("rst stalled stb", 32'(wb.wb_stb_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b0; wb.wb_stall_i = 1'b0;
    checkOutput("rst cyc/stb/ready", 32'({wb.wb_cyc_o, wb.wb_stb_o, dm_ready_o}), 32'b001);
    checkOutput("rst pulses/overlap", 32'({pulses(), dm_overlap_err_o}), 32'd0);
    checkOutput("rst data", dm_data_l_o, 32'd0);

    applyStimulus(finalVec, "post-reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/urv_dmem_wb_bridge.md
Name: urv_dmem_wb_bridge

Overview:
- Responder end of the core's data-memory request port (dm_addr/dm_data_s/dm_data_select/dm_load/dm_store/dm_ready).
- Accepts single-cycle load/store request pulses from the execute stage and performs each as one Wishbone B4 pipelined single access.
- Returns load data and completion pulses to the writeback stage.
- Drives dm_ready_o so the core stalls while an access is outstanding.

Parameters:
- TIMEOUT, 255, cycles in WAIT without ack/err before forcing a bus error. Range 1..1023.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- dm_addr_i  in  32  byte address of request
- dm_data_s_i  in  32  store data, already lane-replicated
- dm_data_select_i  in  4  byte-lane select
- dm_load_i  in  1  load request pulse
- dm_store_i  in  1  store request pulse
- dm_ready_o  out  1  bridge idle, can accept a request
- dm_data_l_o  out  32  load data; valid while dm_load_done_o=1, held afterwards
- dm_load_done_o  out  1  one-cycle load completion pulse
- dm_store_done_o  out  1  one-cycle store completion pulse
- dm_bus_err_o  out  1  one-cycle pulse, access ended by err_i or timeout
- dm_overlap_err_o  out  1  sticky, request seen while busy
- wb_cyc_o  out  1
- wb_stb_o  out  1
- wb_we_o  out  1
- wb_sel_o  out  4
- wb_adr_o  out  32  word address: dm_addr_i[31:2],2'b00
- wb_dat_o  out  32
- wb_dat_i  in  32
- wb_ack_i  in  1
- wb_err_i  in  1
- wb_stall_i  in  1

Behaviour:
- Reset values (sampled on clk_i with rst_i=1):
  - dm_ready_o=1.
  - dm_data_l_o=0.
  - All pulse outputs=0, dm_overlap_err_o=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0.
  - State=IDLE, timeout counter=0.
  - Reset mid-access abandons the access without any completion pulse.
- All outputs are registered. dm_ready_o is a function of state only (no combinational path from dm_load_i/dm_store_i).
- IDLE:
  - dm_ready_o=1.
  - On dm_load_i|dm_store_i, latch adr/sel/dat; we=dm_store_i.
  - Next cycle: wb_cyc_o=1, wb_stb_o=1, dm_ready_o=0; go to ISSUE.
  - If dm_load_i and dm_store_i are both 1, the store wins and the load is dropped.
- ISSUE:
  - Hold stb and all bus fields stable while wb_stall_i=1.
  - On the first cycle with wb_stall_i=0, the beat is accepted; stb deasserts next cycle; go to WAIT.
  - ack/err may arrive in the same cycle as acceptance and must be handled as in WAIT.
- WAIT:
  - cyc stays 1, stb=0, counter increments each cycle.
  - On wb_ack_i:
    - Load: register wb_dat_i into dm_data_l_o and pulse dm_load_done_o.
    - Store: pulse dm_store_done_o.
  - On wb_err_i, or counter reaching TIMEOUT: pulse dm_bus_err_o, plus dm_load_done_o for a load; dm_data_l_o=32'h0.
  - ack and err in the same cycle: err wins.
  - In every case above: cyc=0, dm_ready_o=1, counter cleared, go to IDLE. All of this takes effect in the same registered update.
- Latency, request pulse to done pulse with ack one cycle after accept and no stall: 3 cycles.
  - Cycle N: request.
  - N+1: stb.
  - N+2: ack.
  - N+3: done, ready.
- Back-to-back: a request in the cycle dm_ready_o returns to 1 is accepted normally (no dead cycle).
- A request while dm_ready_o=0:
  - Ignored; the current access is unaffected.
  - dm_overlap_err_o set to 1 until reset.
- The timeout counter is 10 bits and saturates; it does not run in ISSUE.
- ack/err received in IDLE are ignored.

Test Plan:
- Load 0x0000_1004, sel 4'b1111; slave acks one cycle after accept with 0xDEADBEEF -> wb_adr_o=0x1004, we=0, one stb cycle; dm_load_done_o at N+3 with dm_data_l_o=0xDEADBEEF; dm_ready_o low for N+1..N+2.
- Store byte at 0x2003, data 0x5A5A5A5A, sel 4'b1000; wb_stall_i held high 3 cycles -> stb, adr, sel and dat stable for 4 cycles; we=1; dm_store_done_o once after ack.
- Load; slave never responds; TIMEOUT=8 -> dm_bus_err_o and dm_load_done_o pulse exactly 8 WAIT cycles after accept; dm_data_l_o=0; cyc drops.
- ack and err in the same cycle on a store -> dm_bus_err_o=1, dm_store_done_o=1, single pulse each, return to IDLE.
- Second load pulse asserted while in WAIT -> no extra Wishbone cycle; dm_overlap_err_o=1 and stays 1; the first load completes with correct data.
- rst_i asserted while in ISSUE with stall high -> next cycle cyc=0, stb=0, dm_ready_o=1, no done or error pulses; a fresh load then completes normally.
